entropy_seed_fifo: RTL



---
 rtl/entropy_seed_fifo.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/entropy_seed_fifo.sv
// entropy_seed_fifo: samples a raw random bus at a fixed divider rate, packs
// the samples into seed words (optionally whitened against the previous raw
// word) and buffers them in a FIFO drained through an Avalon-MM slave.
// Register map: 0 DATA (read pops), 1 STATUS, 2 CONTROL, 3 reserved.
module entropy_seed_fifo #(
   parameter int IN_WIDTH   = 8,
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int SAMPLE_DIV = 4
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [IN_WIDTH-1:0] pi_random,
   input  logic [1:0]          avs_address,
   input  logic                avs_read,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   output logic [31:0]         avs_readdata,
   output logic                irq
);

   localparam int K     = WORD_WIDTH / IN_WIDTH;
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

   localparam logic [15:0]      DIV_LAST = 16'(SAMPLE_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);
   localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   logic                  r_enable;
   logic                  r_whiten;
   logic [7:0]            r_thresh;
   logic                  r_overflow;
   logic [15:0]           r_div;
   logic [IDX_W-1:0]      r_idx;
   logic [WORD_WIDTH-1:0] r_acc;
   logic [WORD_WIDTH-1:0] r_prev;
   logic [WORD_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_rd_ptr;
   logic [AW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;
   logic [31:0]           r_readdata;
   logic                  r_irq;

   logic                  w_ctrl_wr;
   logic                  w_flush;
   logic                  w_clr_ovf;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_tick;
   logic                  w_word_done;
   logic [WORD_WIDTH-1:0] w_raw;
   logic [WORD_WIDTH-1:0] w_word;
   logic                  w_push;
   logic                  w_ovf_evt;
   logic [31:0]           w_status;
   logic [31:0]           w_control;
   logic                  w_unused;

   assign w_ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
   assign w_flush     = w_ctrl_wr && avs_writedata[3];
   assign w_clr_ovf   = w_ctrl_wr && avs_writedata[2];
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CNT_FULL);
   // Flush owns the FIFO for that cycle, so a concurrent DATA read does not pop.
   assign w_pop       = avs_read && (avs_address == ADDR_DATA) && !w_empty && !w_flush;
   assign w_tick      = r_enable && (r_div == DIV_LAST);
   assign w_raw       = (r_acc << IN_WIDTH) | WORD_WIDTH'(pi_random);
   assign w_word_done = w_tick && (r_idx == IDX_LAST);
   assign w_word      = r_whiten ? (w_raw ^ r_prev) : w_raw;
   // A pop on the same edge frees the slot the new word is written into.
   assign w_push      = w_word_done && (!w_full || w_pop) && !w_flush;
   assign w_ovf_evt   = w_word_done && w_full && !w_pop && !w_flush;

   assign w_status  = {16'h0000, 8'(r_count), 5'b00000, r_overflow, w_full, w_empty};
   assign w_control = {16'h0000, r_thresh, 6'b000000, r_whiten, r_enable};
   assign w_unused  = ^{avs_writedata[31:16], avs_writedata[7:4]};

   assign avs_readdata = r_readdata;
   assign irq          = r_irq;

   // CONTROL register; clear_overflow and flush are pulses and not stored.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_enable <= 1'b0;
         r_whiten <= 1'b0;
         r_thresh <= 8'h00;
      end else if (w_ctrl_wr) begin
         r_enable <= avs_writedata[0];
         r_whiten <= avs_writedata[1];
         r_thresh <= avs_writedata[15:8];
      end
   end

   // Sample divider, sample index and shift accumulator; idle while disabled.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n || w_flush || !r_enable) begin
         r_div <= 16'h0000;
         r_idx <= '0;
         r_acc <= '0;
      end else if (w_tick) begin
         r_div <= 16'h0000;
         r_acc <= w_raw;
         r_idx <= w_word_done ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_div <= r_div + 16'h0001;
      end
   end

   // Previous raw word for whitening, tracked whether or not whitening is on.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n || w_flush) begin
         r_prev <= '0;
      end else if (w_word_done) begin
         r_prev <= w_raw;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n || w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // FIFO storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   // Sticky overflow; a drop in the same cycle beats a clear request.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_overflow <= 1'b0;
      end else if (w_ovf_evt) begin
         r_overflow <= 1'b1;
      end else if (w_clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   // Registered read mux; the value holds until the next read strobe.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_readdata <= 32'h0000_0000;
      end else if (avs_read) begin
         case (avs_address)
            ADDR_DATA:   r_readdata <= w_empty ? 32'h0000_0000 : 32'(r_mem[r_rd_ptr]);
            ADDR_STATUS: r_readdata <= w_status;
            ADDR_CTRL:   r_readdata <= w_control;
            default:     r_readdata <= 32'h0000_0000;
         endcase
      end
   end

   // Level interrupt on occupancy threshold; zero threshold disables it.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (r_thresh != 8'h00) && (8'(r_count) >= r_thresh);
      end
   end

endmodule
